data_stack: RTL



---
 rtl/data_stack.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_stack.sv
// data_stack: LIFO operand stack for the stack-machine datapath.
//
// Accepts one push and/or pop strobe per cycle from the control FSM. It stores
// WIDTH-bit words and returns the popped top-of-stack on a registered output.
// A three-state occupancy FSM drives the registered empty/full flags.
//
// Optional feature macro: DATA_STACK_ERR_EN
//   defined     -> sticky overflow/underflow flags, cleared only by rst/rst_stack
//   not defined -> overflow/underflow tied to 0 (illegal ops are still ignored)

module data_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_stack,
    input  logic             push_stack,
    input  logic             pop_stack,
    input  logic [WIDTH-1:0] stack_data_in,
    output logic [WIDTH-1:0] stack_data_out,
    output logic [PTR_W-1:0] tos_pointer,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StPartial = 2'd1,
        StFull    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   tos_q, tos_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               empty_q, full_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               clr;
    logic               push_only, pop_only, push_pop;
    logic               is_empty, is_full;
    logic               net_push, net_pop, replace;
    logic               wr_en, rd_en;
    logic [ADDR_W-1:0]  top_addr, free_addr, wr_addr;

    // Decode strobes into the operation that actually takes effect this cycle.
    always_comb begin
        clr       = rst | rst_stack;
        push_only = push_stack & ~pop_stack;
        pop_only  = pop_stack & ~push_stack;
        push_pop  = push_stack & pop_stack;
        is_empty  = (state_q == StEmpty);
        is_full   = (state_q == StFull);

        // Push+pop on an empty stack degrades to a plain push.
        net_push  = ~clr & ((push_only & ~is_full) | (push_pop & is_empty));
        net_pop   = ~clr & pop_only & ~is_empty;
        replace   = ~clr & push_pop & ~is_empty;

        // Address arithmetic is only meaningful when the matching op is legal.
        top_addr  = ADDR_W'(tos_q - PtrOne);
        free_addr = ADDR_W'(tos_q);

        wr_en     = net_push | replace;
        wr_addr   = replace ? top_addr : free_addr;
        rd_en     = net_pop | replace;
    end

    // Next pointer, next occupancy state and next output word.
    always_comb begin
        tos_d = tos_q;
        if (net_push) begin
            tos_d = tos_q + PtrOne;
        end else if (net_pop) begin
            tos_d = tos_q - PtrOne;
        end

        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (net_push) begin
                    state_d = StPartial;
                end
            end
            StPartial: begin
                if (net_push && (tos_q == PtrLast)) begin
                    state_d = StFull;
                end else if (net_pop && (tos_q == PtrOne)) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (net_pop) begin
                    state_d = StPartial;
                end
            end
            default: state_d = StEmpty;
        endcase

        dout_d = rd_en ? mem_q[top_addr] : dout_q;
    end

    // Occupancy FSM with registered pointer, data output and status flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StEmpty;
            tos_q   <= '0;
            dout_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            dout_q  <= dout_d;
            empty_q <= (state_d == StEmpty);
            full_q  <= (state_d == StFull);
        end
    end

    // Storage array; contents survive reset, only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= stack_data_in;
        end
    end

`ifdef DATA_STACK_ERR_EN
    logic overflow_q, underflow_q;
    logic over_set, under_set;

    // Illegal-op detection; push+pop on empty still counts as an empty pop.
    always_comb begin
        over_set  = push_only & is_full;
        under_set = pop_stack & is_empty;
    end

    // Sticky error flags, cleared only by a reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (over_set) begin
                overflow_q <= 1'b1;
            end
            if (under_set) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign stack_data_out = dout_q;
    assign tos_pointer    = tos_q;
    assign empty          = empty_q;
    assign full           = full_q;

endmodule
